// File: rtl/fs_port_arbiter.sv
// Two-port round-robin arbiter in front of a single filesystem swap port.
// One command in flight at a time; reads return after READ_LAT cycles.
module fs_port_arbiter #(
    parameter int unsigned READ_LAT = 2
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic        r0_meta,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_ack,
    output logic        r0_rvalid,
    output logic [31:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic        r1_meta,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_ack,
    output logic        r1_rvalid,
    output logic [31:0] r1_rdata,
    output logic        swapMeta,
    output logic [31:0] swapAddress,
    output logic        swapRden,
    output logic        swapWren,
    output logic [31:0] swapData,
    input  logic [31:0] swapQ,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;     // requester currently being served
    logic        prio_q, prio_d;   // requester that wins a tie
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        meta_q, meta_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        pick;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d  = state_q;
        gnt_d    = gnt_q;
        prio_d   = prio_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        meta_d   = meta_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rvalid_d = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        pick     = prio_q;

        case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
                    pick    = (r0_req && r1_req) ? prio_q : r1_req;
                    gnt_d   = pick;
                    prio_d  = ~pick;
                    we_d    = pick ? r1_we    : r0_we;
                    meta_d  = pick ? r1_meta  : r0_meta;
                    addr_d  = pick ? r1_addr  : r0_addr;
                    wdata_d = pick ? r1_wdata : r0_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = LAT_M1;
                    state_d = (LAT_M1 == 4'd0) ? RESP : RDWAIT;
                end
            end
            RDWAIT: begin
                // Leaving when the counter reaches zero lands RESP exactly READ_LAT after ISSUE.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP: begin
                state_d         = IDLE;
                rvalid_d[gnt_q] = 1'b1;
                if (gnt_q) rdata1_d = swapQ;
                else       rdata0_d = swapQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            prio_q   <= 1'b0;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            meta_q   <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rvalid_q <= 2'b00;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            prio_q   <= prio_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            meta_q   <= meta_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign r0_ack      = (state_q == ISSUE) && !gnt_q;
    assign r1_ack      = (state_q == ISSUE) &&  gnt_q;
    assign swapWren    = (state_q == ISSUE) &&  we_q;
    assign swapRden    = (state_q == ISSUE) && !we_q;
    assign swapMeta    = meta_q;
    assign swapAddress = addr_q;
    assign swapData    = wdata_q;
    assign r0_rvalid   = rvalid_q[0];
    assign r1_rvalid   = rvalid_q[1];
    assign r0_rdata    = rdata0_q;
    assign r1_rdata    = rdata1_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fs_port_arbiter.sv
// Bench for fs_port_arbiter: two instances (READ_LAT 2 and 1) share stimulus and
// are each compared every cycle against a timeline model of the arbiter.
module tb_fs_port_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        r0_req, r0_we, r0_meta, r1_req, r1_we, r1_meta;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic [31:0] swap_q;

    logic        a0 [2], a1 [2], v0 [2], v1 [2];
    logic [31:0] d0 [2], d1 [2];
    logic        smeta [2], srd [2], swr [2], bsy [2];
    logic [31:0] saddr [2], sdat [2];

    int n_chk = 0;
    int n_bad = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fs_port_arbiter #(.READ_LAT(g == 0 ? 2 : 1)) u_dut (
            .CLOCK_50(CLOCK_50), .reset(reset),
            .r0_req(r0_req), .r0_we(r0_we), .r0_meta(r0_meta), .r0_addr(r0_addr),
            .r0_wdata(r0_wdata), .r0_ack(a0[g]), .r0_rvalid(v0[g]), .r0_rdata(d0[g]),
            .r1_req(r1_req), .r1_we(r1_we), .r1_meta(r1_meta), .r1_addr(r1_addr),
            .r1_wdata(r1_wdata), .r1_ack(a1[g]), .r1_rvalid(v1[g]), .r1_rdata(d1[g]),
            .swapMeta(smeta[g]), .swapAddress(saddr[g]), .swapRden(srd[g]),
            .swapWren(swr[g]), .swapData(sdat[g]), .swapQ(swap_q), .busy(bsy[g])
        );
    end

    task automatic check1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
    endtask

    // Filesystem read data: a changing pattern, or a fixed word when a test pins it.
    logic        q_fix_en = 1'b0;
    logic [31:0] q_fix = 32'd0;
    logic [31:0] q_ctr = 32'd0;
    always @(negedge CLOCK_50) begin
        q_ctr  = q_ctr + 32'h0001_0101;
        swap_q = q_fix_en ? q_fix : (32'hA500_0000 ^ q_ctr);
    end

    // Timeline model: a grant at edge e gives ack/strobe after e; a write frees the
    // port after e+1, a read delivers rvalid (and frees the port) after e+LAT+1.
    int          cyc = 0;
    bit          model_ok = 1'b0;
    int          idle_from [2], iss_at [2], rv_at [2];
    logic        gnt_m [2], rr_m [2], we_m [2], meta_m [2];
    logic [31:0] addr_m [2], wd_m [2], rd0_m [2], rd1_m [2];

    always @(posedge CLOCK_50) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            int   lat;
            logic n;
            lat = (i == 0) ? 2 : 1;
            if (reset) begin
                idle_from[i] = cyc; iss_at[i] = -1; rv_at[i] = -1;
                gnt_m[i] = 1'b0; rr_m[i] = 1'b0; we_m[i] = 1'b0; meta_m[i] = 1'b0;
                addr_m[i] = 32'd0; wd_m[i] = 32'd0; rd0_m[i] = 32'd0; rd1_m[i] = 32'd0;
            end else begin
                if (cyc == rv_at[i]) begin
                    if (gnt_m[i]) rd1_m[i] = swap_q;
                    else          rd0_m[i] = swap_q;
                end
                if ((cyc - 1) >= idle_from[i] && (r0_req || r1_req)) begin
                    n         = (r0_req && r1_req) ? rr_m[i] : r1_req;
                    gnt_m[i]  = n;
                    rr_m[i]   = !n;
                    we_m[i]   = n ? r1_we    : r0_we;
                    meta_m[i] = n ? r1_meta  : r0_meta;
                    addr_m[i] = n ? r1_addr  : r0_addr;
                    wd_m[i]   = n ? r1_wdata : r0_wdata;
                    iss_at[i] = cyc;
                    if (we_m[i]) idle_from[i] = cyc + 1;
                    else begin
                        idle_from[i] = cyc + lat + 1;
                        rv_at[i]     = cyc + lat + 1;
                    end
                end
            end
        end
        if (reset) model_ok = 1'b1;
    end

    always @(negedge CLOCK_50) begin
        if (model_ok) begin
            for (int i = 0; i < 2; i++) begin
                bit    iss, rv;
                string p;
                iss = (cyc == iss_at[i]);
                rv  = (cyc == rv_at[i]);
                p   = $sformatf("lat%0d_", (i == 0) ? 2 : 1);
                check1({p, "r0_ack"},    a0[i],    iss && !gnt_m[i]);
                check1({p, "r1_ack"},    a1[i],    iss &&  gnt_m[i]);
                check1({p, "swapWren"},  swr[i],   iss &&  we_m[i]);
                check1({p, "swapRden"},  srd[i],   iss && !we_m[i]);
                check1({p, "r0_rvalid"}, v0[i],    rv && !gnt_m[i]);
                check1({p, "r1_rvalid"}, v1[i],    rv &&  gnt_m[i]);
                check1({p, "busy"},      bsy[i],   cyc < idle_from[i]);
                check1({p, "swapMeta"},  smeta[i], meta_m[i]);
                check32({p, "swapAddress"}, saddr[i], addr_m[i]);
                check32({p, "swapData"},    sdat[i],  wd_m[i]);
                check32({p, "r0_rdata"},    d0[i],    rd0_m[i]);
                check32({p, "r1_rdata"},    d1[i],    rd1_m[i]);
            end
        end
    end

    task automatic wait_ack(input int inst, input bit n, input string nm);
        int k;
        k = 0;
        while (!(n ? a1[inst] : a0[inst]) && k < 20) begin
            tick();
            k++;
        end
        check1({nm, "_ack_seen"}, n ? a1[inst] : a0[inst], 1'b1);
    endtask

    initial begin
        int seq [4];
        int n_seen;
        int hits;

        reset = 1'b1;
        r0_req = 0; r0_we = 0; r0_meta = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_meta = 0; r1_addr = 0; r1_wdata = 0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check1("rst_busy", bsy[0], 1'b0);
        check32("rst_swapAddress", saddr[0], 32'd0);

        // r0 write: ack and write strobe one cycle after the request is seen.
        r0_we = 1; r0_addr = 32'h10; r0_wdata = 32'hDEAD_BEEF; r0_req = 1;
        tick();
        check1("wr_r0_ack", a0[0], 1'b1);
        check1("wr_swapWren", swr[0], 1'b1);
        check1("wr_swapRden", srd[0], 1'b0);
        check32("wr_swapAddress", saddr[0], 32'h10);
        check32("wr_swapData", sdat[0], 32'hDEAD_BEEF);
        r0_req = 0;
        tick();
        check1("wr_busy_after", bsy[0], 1'b0);

        // r1 metadata write.
        r1_we = 1; r1_meta = 1; r1_addr = 32'h44; r1_wdata = 32'h5555_AAAA; r1_req = 1;
        wait_ack(0, 1'b1, "meta_wr");
        check1("meta_wr_swapMeta", smeta[0], 1'b1);
        r1_req = 0;
        repeat (2) tick();

        // r1 read with a pinned return word.
        q_fix_en = 1; q_fix = 32'h1234_5678;
        r1_we = 0; r1_meta = 0; r1_addr = 32'h20; r1_req = 1;
        tick();
        check1("rd_r1_ack", a1[0], 1'b1);
        check1("rd_swapRden", srd[0], 1'b1);
        check32("rd_swapAddress", saddr[0], 32'h20);
        r1_req = 0;
        repeat (2) tick();
        check1("rd_rvalid_early", v1[0], 1'b0);
        tick();
        check1("rd_r1_rvalid", v1[0], 1'b1);
        check32("rd_r1_rdata", d1[0], 32'h1234_5678);
        check32("rd_r0_rdata_kept", d0[0], 32'd0);
        q_fix_en = 0;
        repeat (3) tick();

        // Both requesting reads continuously: grants must alternate r0, r1, r0, r1.
        r0_we = 0; r0_addr = 32'h100; r1_we = 0; r1_addr = 32'h200;
        r0_req = 1; r1_req = 1;
        n_seen = 0;
        for (int k = 0; k < 40 && n_seen < 4; k++) begin
            tick();
            if (a0[0]) begin seq[n_seen] = 0; n_seen++; end
            else if (a1[0]) begin seq[n_seen] = 1; n_seen++; end
        end
        check32("rr_grant_count", 32'(n_seen), 32'd4);
        for (int k = 0; k < n_seen; k++)
            check32($sformatf("rr_grant%0d", k), 32'(seq[k]), 32'(k % 2));
        r0_req = 0; r1_req = 0;
        repeat (8) tick();

        // Reset one cycle into a read aborts it.
        r0_addr = 32'h300; r0_req = 1;
        wait_ack(0, 1'b0, "abort");
        r0_req = 0;
        tick();
        reset = 1;
        tick();
        check1("abort_busy", bsy[0], 1'b0);
        check1("abort_rden", srd[0], 1'b0);
        check32("abort_swapAddress", saddr[0], 32'd0);
        check32("abort_swapData", sdat[0], 32'd0);
        check32("abort_r1_rdata", d1[0], 32'd0);
        reset = 0;
        hits = 0;
        repeat (10) begin
            tick();
            if (v0[0] || v0[1]) hits++;
        end
        check32("abort_no_rvalid", 32'(hits), 32'd0);

        // READ_LAT=1 back-to-back reads: rvalid at T+2, next ack at T+3.
        r0_addr = 32'd1; r0_req = 1;
        wait_ack(1, 1'b0, "l1_first");
        r0_addr = 32'd2;
        tick();
        check1("l1_rvalid_t1", v0[1], 1'b0);
        tick();
        check1("l1_rvalid_t2", v0[1], 1'b1);
        check1("l1_ack_t2", a0[1], 1'b0);
        tick();
        check1("l1_ack_t3", a0[1], 1'b1);
        check32("l1_addr_t3", saddr[1], 32'd2);
        r0_req = 0;
        repeat (2) tick();
        check1("l1_rvalid_second", v0[1], 1'b1);
        repeat (4) tick();

        // r1 pulses while r0 is in flight; r0 inputs change after ack.
        r0_addr = 32'h40; r0_req = 1;
        wait_ack(0, 1'b0, "pulse");
        r0_req = 0; r0_addr = 32'hFFFF_FFFF;
        r1_req = 1; r1_we = 1;
        tick();
        r1_req = 0;
        check32("pulse_addr_held", saddr[0], 32'h40);
        hits = 0;
        repeat (8) begin
            tick();
            if (a1[0] || a1[1] || swr[0] || swr[1]) hits++;
        end
        check32("pulse_no_r1_cmd", 32'(hits), 32'd0);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fs_port_arbiter.md
FS_PORT_ARBITER -- requirements
Module: fs_port_arbiter

Interface
REQ-001 Parameter READ_LAT, default 2: cycles from swapRden high to swapQ valid; legal range 1..15.
REQ-002 CLOCK_50  in  1  sole clock, all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 rN_req  in  1  (N=0,1) requester N command pending; held until rN_ack.
REQ-005 rN_we  in  1  (N=0,1) 1=write, 0=read.
REQ-006 rN_meta  in  1  (N=0,1) select metadata space (drives swapMeta).
REQ-007 rN_addr  in  32  (N=0,1) word address.
REQ-008 rN_wdata  in  32  (N=0,1) write data.
REQ-009 rN_ack  out  1  (N=0,1) one-cycle pulse: command accepted and issued.
REQ-010 rN_rvalid  out  1  (N=0,1) one-cycle pulse: rN_rdata valid.
REQ-011 rN_rdata  out  32  (N=0,1) read return data.
REQ-012 swapMeta  out  1  to filesystem.
REQ-013 swapAddress  out  32  to filesystem.
REQ-014 swapRden  out  1  to filesystem, read strobe.
REQ-015 swapWren  out  1  to filesystem, write strobe.
REQ-016 swapData  out  32  to filesystem, write data.
REQ-017 swapQ  in  32  from filesystem, read data.
REQ-018 busy  out  1  high whenever state != IDLE.

Function
REQ-019 States SHALL be IDLE, ISSUE, RDWAIT, RESP; one command in flight at most.
REQ-020 IDLE: if no rN_req, stay; else grant one requester, latch its we/meta/addr/wdata, go ISSUE next cycle.
REQ-021 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; after reset, r0 has priority.
REQ-022 Round-robin pointer SHALL update only on grant.
REQ-023 Single requester active SHALL be granted regardless of pointer; no idle bubble beyond the IDLE cycle.
REQ-024 ISSUE (cycle T): assert granted rN_ack for exactly one cycle; assert swapWren (write) or swapRden (read) for exactly that cycle.
REQ-025 swapAddress/swapData/swapMeta SHALL carry latched values from ISSUE through end of RDWAIT; otherwise hold last values.
REQ-026 ISSUE write: next state IDLE; write occupancy = 2 cycles (IDLE, ISSUE).
REQ-027 ISSUE read: load 4-bit counter with READ_LAT-1, go RDWAIT (or straight to RESP if READ_LAT=1).
REQ-028 RDWAIT: decrement each cycle; at 0, go RESP.
REQ-029 RESP (cycle T+READ_LAT): sample swapQ into granted rN_rdata; assert rN_rvalid for one cycle at T+READ_LAT+1 concurrent with IDLE.
REQ-030 rN_rdata SHALL hold value until next rvalid for same requester; other requester's rdata unaffected.
REQ-031 swapRden and swapWren SHALL never be high simultaneously and never high outside ISSUE.
REQ-032 rN_req dropped before grant: no command issued, no ack.
REQ-033 rN_req still high in IDLE after completion: treated as new command.
REQ-034 Requester inputs changed after ack SHALL not affect the in-flight command.

Reset
REQ-035 On reset: state IDLE, pointer favours r0, counter 0, all acks/rvalids/swapRden/swapWren 0, swapAddress/swapData 0, swapMeta 0, rN_rdata 0, busy 0.
REQ-036 Reset mid-read SHALL abort: no rvalid produced for the aborted command, even if swapQ arrives later.
REQ-037 First cycle after reset release SHALL be IDLE evaluation.

Verification
REQ-038 r0 write addr=0x10 data=0xDEADBEEF -> one cycle later r0_ack=1, swapWren=1, swapAddress=0x10, swapData=0xDEADBEEF; busy low next cycle.
REQ-039 READ_LAT=2, r1 read addr=0x20, model returns 0x12345678 -> swapRden at T, r1_rvalid at T+3 with r1_rdata=0x12345678; r0_rdata unchanged.
REQ-040 r0 and r1 request together, held continuously, both reads -> grants r0, r1, r0, r1 alternate; no two strobes overlap.
REQ-041 Reset asserted at T+1 of a read -> no rvalid ever, all outputs at reset values next cycle.
REQ-042 READ_LAT=1, back-to-back r0 reads addr 1,2 -> each rvalid at T+2, command occupancy 3 cycles.
REQ-043 r1_req pulsed one cycle while r0 in flight, then dropped -> r1 never acked, no swap strobe for r1.
